// File: rtl/matrix_engine.sv
// matrix_engine: NxN accumulator matrix engine with valid/ready command interface and row-serial in-place multiply
module matrix_engine #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int CW = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [CW-1:0]     cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N*N*DW-1:0] Matrix_in,
    output logic [N*N*DW-1:0] Matrix_out,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic [1:0]        state_sim
);
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] C_NOP = CW'(0);
    localparam logic [CW-1:0] C_LOAD = CW'(1);
    localparam logic [CW-1:0] C_ADD = CW'(2);
    localparam logic [CW-1:0] C_MUL = CW'(3);
    localparam logic [CW-1:0] C_TRN = CW'(4);
    localparam logic [CW-1:0] C_SCL = CW'(5);
    localparam logic [CW-1:0] C_CLR = CW'(6);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_row;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];
    logic [DW-1:0]   w_b [N][N];
    logic [DW-1:0]   w_row [N];
    logic [DW-1:0]   w_scl [N][N];
    logic [2*DW-1:0] w_p;
    logic [2*DW-1:0] w_q;
    logic            w_accept;
    logic            w_last;

    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign w_b[r][c] = Matrix_in[(r*N+c)*DW +: DW];
            assign Matrix_out[(r*N+c)*DW +: DW] = r_a[r][c];
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = !cmd_ready;
    assign done      = r_done;
    assign cmd_err   = r_err;
    assign state_sim = r_state;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_last    = (r_row == RW'(N-1));

    // Dot product of the current A row with every column of the latched B, full-width products, modulo-2^DW sum
    always_comb begin
        w_p = '0;
        for (int c = 0; c < N; c++) begin
            w_row[c] = '0;
            for (int k = 0; k < N; k++) begin
                w_p = {{DW{1'b0}}, r_a[r_row][k]} * {{DW{1'b0}}, r_b[k][c]};
                w_row[c] = w_row[c] + DW'(w_p);
            end
        end
    end

    // Every element of A scaled by B(0,0), truncated to DW bits
    always_comb begin
        w_q = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                w_q = {{DW{1'b0}}, r_a[i][j]} * {{DW{1'b0}}, w_b[0][0]};
                w_scl[i][j] = DW'(w_q);
            end
    end

    // Next state: IDLE->MUL on a MUL accept, MUL->IDLE after the last row, stray encodings back to IDLE
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE) w_next = (w_accept && cmd == C_MUL) ? MUL : IDLE;
        else if (r_state == MUL) w_next = w_last ? IDLE : MUL;
    end

    // State, accumulator, latched operand and status pulses
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                case (cmd)
                    C_NOP: r_done <= 1'b1;
                    C_LOAD: begin
                        r_a    <= w_b;
                        r_done <= 1'b1;
                    end
                    C_ADD: begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) r_a[i][j] <= r_a[i][j] + w_b[i][j];
                        r_done <= 1'b1;
                    end
                    C_MUL: begin
                        r_b   <= w_b;
                        r_row <= '0;
                    end
                    C_TRN: begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) r_a[i][j] <= r_a[j][i];
                        r_done <= 1'b1;
                    end
                    C_SCL: begin
                        r_a    <= w_scl;
                        r_done <= 1'b1;
                    end
                    C_CLR: begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) r_a[i][j] <= '0;
                        r_done <= 1'b1;
                    end
                    default: r_err <= 1'b1;
                endcase
            end else if (r_state == MUL) begin
                r_a[r_row] <= w_row;
                r_row      <= r_row + 1'b1;
                r_done     <= w_last;
            end
        end
    end
endmodule

// File: tb/tb_matrix_engine.sv
// tb_matrix_engine: vector table, corner-case sequences and randomized model check for matrix_engine
module tb_matrix_engine;
    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   cmd;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] min;
    logic [255:0] mout;
    logic         busy;
    logic         done;
    logic         cmd_err;
    logic [1:0]   state_sim;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]   cmd;
        logic [255:0] b;
        logic [255:0] exp_a;
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    vec_t        tbl[11];
    logic [15:0] m_a [4][4];

    always #5 clk = ~clk;

    matrix_engine #(.N(4), .DW(16), .CW(3)) dut (
        .CLK(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .Matrix_in(min), .Matrix_out(mout), .busy(busy), .done(done), .cmd_err(cmd_err),
        .state_sim(state_sim)
    );

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // kind: 0 all v, 1 identity, 2 r*4+c+1, 3 r+c, 4 rows 4r+6, 5 columns 4c+6
    function automatic logic [255:0] gen(input int kind, input logic [15:0] v);
        logic [255:0] m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4+c)*16 +: 16] = kind == 0 ? v : kind == 1 ? 16'(r == c) : kind == 2 ? 16'(r*4+c+1) :
                                      kind == 3 ? 16'(r+c) : kind == 4 ? 16'(4*r+6) : 16'(4*c+6);
        return m;
    endfunction

    function automatic logic [255:0] mpack();
        logic [255:0] m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[(r*4+c)*16 +: 16] = m_a[r][c];
        return m;
    endfunction

    // Reference: apply one command to the model accumulator using plain matrix arithmetic
    task automatic model_apply(input logic [2:0] c, input logic [255:0] b);
        logic [15:0] t [4][4];
        longint s;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) t[r][k] = m_a[r][k];
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                case (c)
                    3'd1: t[r][k] = b[(r*4+k)*16 +: 16];
                    3'd2: t[r][k] = m_a[r][k] + b[(r*4+k)*16 +: 16];
                    3'd3: begin
                        s = 0;
                        for (int j = 0; j < 4; j++) s += longint'(m_a[r][j]) * longint'(b[(j*4+k)*16 +: 16]);
                        t[r][k] = s[15:0];
                    end
                    3'd4: t[r][k] = m_a[k][r];
                    3'd5: begin
                        s = longint'(m_a[r][k]) * longint'(b[15:0]);
                        t[r][k] = s[15:0];
                    end
                    3'd6: t[r][k] = '0;
                    default: t[r][k] = m_a[r][k];
                endcase
            end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) m_a[r][k] = t[r][k];
    endtask

    // Present one command, let it be accepted, then wait (bounded) for done or cmd_err
    task automatic issue(input logic [2:0] c, input logic [255:0] b);
        int n;
        @(negedge clk);
        cmd = c;
        min = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!done && !cmd_err && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 20) begin
            n_fail++;
            $display("FAIL timeout: no done/cmd_err for cmd %0d after %0d cycles", c, n);
        end
    endtask

    initial begin
        int dones;
        logic [2:0]   rc;
        logic [255:0] rb;
        tbl[0]  = '{3'd1, gen(0, 16'hFFFF), gen(0, 16'hFFFF), 1'b1, 1'b0};
        tbl[1]  = '{3'd2, gen(0, 16'h0002), gen(0, 16'h0001), 1'b1, 1'b0};
        tbl[2]  = '{3'd5, gen(0, 16'h8000), gen(0, 16'h8000), 1'b1, 1'b0};
        tbl[3]  = '{3'd7, gen(2, 16'h0000), gen(0, 16'h8000), 1'b0, 1'b1};
        tbl[4]  = '{3'd0, gen(3, 16'h0000), gen(0, 16'h8000), 1'b1, 1'b0};
        tbl[5]  = '{3'd1, gen(3, 16'h0000), gen(3, 16'h0000), 1'b1, 1'b0};
        tbl[6]  = '{3'd3, gen(0, 16'h0001), gen(4, 16'h0000), 1'b1, 1'b0};
        tbl[7]  = '{3'd4, gen(0, 16'h1234), gen(5, 16'h0000), 1'b1, 1'b0};
        tbl[8]  = '{3'd6, gen(0, 16'h5555), gen(0, 16'h0000), 1'b1, 1'b0};
        tbl[9]  = '{3'd1, gen(1, 16'h0000), gen(1, 16'h0000), 1'b1, 1'b0};
        tbl[10] = '{3'd3, gen(2, 16'h0000), gen(2, 16'h0000), 1'b1, 1'b0};

        reset = 1'b1;
        cmd = '0;
        cmd_valid = 1'b0;
        min = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_A", mout, '0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", cmd_err, 0);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_state", state_sim, 0);

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].cmd, tbl[i].b);
            chk($sformatf("vec%0d_A", i), mout, tbl[i].exp_a);
            chk($sformatf("vec%0d_done", i), done, tbl[i].exp_done);
            chk($sformatf("vec%0d_err", i), cmd_err, tbl[i].exp_err);
        end

        // Identity multiply timing: busy for 4 cycles, done in the 5th
        issue(3'd1, gen(1, 0));
        @(negedge clk);
        cmd = 3'd3;
        min = gen(2, 0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("id_busy_c%0d", i), busy, 1);
            chk($sformatf("id_nodone_c%0d", i), done, 0);
            chk($sformatf("id_state_c%0d", i), state_sim, 1);
            @(posedge clk);
            #1;
        end
        chk("id_busy_end", busy, 0);
        chk("id_done_end", done, 1);
        chk("id_A", mout, gen(2, 0));
        @(posedge clk);
        #1 chk("id_done_once", done, 0);

        // Handshake: LOAD held valid through a MUL is taken in the done cycle
        issue(3'd1, gen(3, 0));
        @(negedge clk);
        cmd = 3'd3;
        min = gen(0, 16'h0001);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd = 3'd1;
        min = gen(1, 0);
        dones = 0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("hs_ready_c%0d", i), cmd_ready, 0);
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        chk("hs_mul_done", done, 1);
        chk("hs_mul_A", mout, gen(4, 0));
        chk("hs_ready_done", cmd_ready, 1);
        if (done) dones++;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("hs_load_done", done, 1);
        chk("hs_load_A", mout, gen(1, 0));
        if (done) dones++;
        @(posedge clk);
        #1 if (done) dones++;
        chk("hs_done_count", 256'(dones), 256'(2));

        // Reset two cycles after a MUL accept aborts it
        issue(3'd1, gen(2, 0));
        @(negedge clk);
        cmd = 3'd3;
        min = gen(0, 16'h0001);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_A", mout, '0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk($sformatf("rst_nodone_c%0d", i), done, 0);
            chk($sformatf("rst_A_c%0d", i), mout, '0);
        end
        issue(3'd1, gen(0, 16'h00AB));
        chk("rst_load_A", mout, gen(0, 16'h00AB));
        chk("rst_load_done", done, 1);

        // Randomized commands against the reference model
        issue(3'd6, '0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m_a[r][c] = '0;
        for (int i = 0; i < 80; i++) begin
            rc = 3'($urandom_range(0, 7));
            for (int e = 0; e < 16; e++)
                rb[e*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 7));
            issue(rc, rb);
            model_apply(rc, rb);
            chk($sformatf("rnd%0d_A cmd%0d", i, rc), mout, mpack());
            chk($sformatf("rnd%0d_done", i), done, rc != 3'd7);
            chk($sformatf("rnd%0d_err", i), cmd_err, rc == 3'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
